// File: rtl/shift_sched_if.sv
// Bundle of the two requester channels and the response channel of shift_sched.
// The design side uses the slave modport. The requester/consumer side uses the master modport.
interface shift_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_data;
    logic [3:0]  req0_amt;
    logic        req0_lr;
    logic [1:0]  req0_op;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_data;
    logic [3:0]  req1_amt;
    logic        req1_lr;
    logic [1:0]  req1_op;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_id;
    logic        rsp_carry;
    logic        rsp_zero;

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_lr, req0_op,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt, req1_lr, req1_op,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id, rsp_carry, rsp_zero,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_data, req0_amt, req0_lr, req0_op,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt, req1_lr, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id, rsp_carry, rsp_zero,
        output rsp_ready
    );
endinterface

// File: rtl/shift_sched.sv
// Two-requester shift/rotate unit with a round-robin arbiter.
// The unit runs one operation at a time through the states IDLE -> EXEC -> RESP.
// All shift forms share a single 16-bit left rotator. A right rotate by N is performed as a left rotate by 16-N.
// Shifts clear, or sign-fill, the vacated end of the rotator output through a mask.
module shift_sched (
    input  logic         clk,
    input  logic         rst_n,
    shift_sched_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [15:0] opd_q, opd_d;
    logic [3:0]  amt_q, amt_d;
    logic        lr_q, lr_d;
    logic [1:0]  op_q, op_d;
    logic        id_q, id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_carry_q, rsp_carry_d;
    logic        rsp_zero_q, rsp_zero_d;

    logic        grant_s;
    logic        ready0_s;
    logic        ready1_s;
    logic        accept_s;
    logic [3:0]  rot_amt_s;
    logic [15:0] rot_s;
    logic [15:0] mask_s;
    logic [15:0] res_s;
    logic        carry_s;

    // Circular left rotate of a 16-bit word by 0..15 positions.
    function automatic logic [15:0] rotl16(input logic [15:0] v, input logic [3:0] s);
        logic [31:0] w;
        w = {v, v} << s;
        return w[31:16];
    endfunction

    // Grant choice: a lone valid requester wins. On a tie, the requester that was not granted last wins.
    always_comb begin
        grant_s = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_q;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign ready0_s       = rst_n && (state_q == S_IDLE) && bus.req0_valid && (grant_s == 1'b0);
    assign ready1_s       = rst_n && (state_q == S_IDLE) && bus.req1_valid && (grant_s == 1'b1);
    assign accept_s       = ready0_s || ready1_s;
    assign bus.req0_ready = ready0_s;
    assign bus.req1_ready = ready1_s;

    // Datapath: one rotator. The mask selects the amt vacated bit positions, which are cleared or sign-filled.
    always_comb begin
        rot_amt_s = lr_q ? amt_q : (4'd0 - amt_q);
        rot_s     = rotl16(opd_q, rot_amt_s);
        mask_s    = lr_q ? ((16'h0001 << amt_q) - 16'h0001) : ~(16'hFFFF >> amt_q);
        carry_s   = (amt_q != 4'd0) ? (lr_q ? rot_s[0] : rot_s[15]) : 1'b0;
        case (op_q)
            2'b00: res_s = rot_s;
            2'b01: res_s = rot_s & ~mask_s;
            2'b10: res_s = (rot_s & ~mask_s) | ((!lr_q && opd_q[15]) ? mask_s : 16'h0000);
            2'b11: begin
                res_s   = opd_q;
                carry_s = 1'b0;
            end
            default: begin
                res_s   = 16'h0000;
                carry_s = 1'b0;
            end
        endcase
    end

    // Next-state and next-register computation for the controller and its latched operands.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        opd_d       = opd_q;
        amt_d       = amt_q;
        lr_d        = lr_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_EXEC;
                    last_d  = grant_s;
                    id_d    = grant_s;
                    if (grant_s) begin
                        opd_d = bus.req1_data;
                        amt_d = bus.req1_amt;
                        lr_d  = bus.req1_lr;
                        op_d  = bus.req1_op;
                    end else begin
                        opd_d = bus.req0_data;
                        amt_d = bus.req0_amt;
                        lr_d  = bus.req0_lr;
                        op_d  = bus.req0_op;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = res_s;
                rsp_id_d    = id_q;
                rsp_carry_d = carry_s;
                rsp_zero_d  = (res_s == 16'h0000);
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset drops any in-flight operation so that req0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            opd_q       <= 16'h0000;
            amt_q       <= 4'd0;
            lr_q        <= 1'b0;
            op_q        <= 2'b00;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_id_q    <= 1'b0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            opd_q       <= opd_d;
            amt_q       <= amt_d;
            lr_q        <= lr_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_shift_sched.sv
// Testbench for shift_sched. Directed cases run first, then randomized operations.
// The reference model shifts one bit at a time and tracks the round-robin pointer.
module tb_shift_sched;

    logic clk;
    logic rst_n;
    shift_sched_if bus_if ();

    shift_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic model_last   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: apply amt single-bit steps. Result {carry, data}.
    function automatic logic [16:0] ref_op(input logic [15:0] d, input logic [3:0] amt,
                                           input logic lr, input logic [1:0] op);
        logic [15:0] v;
        logic        c;
        v = d;
        c = 1'b0;
        if (op == 2'b11) return {1'b0, d};
        for (int i = 0; i < int'(amt); i++) begin
            if (lr) begin
                c = v[15];
                v = {v[14:0], (op == 2'b00) ? v[15] : 1'b0};
            end else begin
                c = v[0];
                v = {(op == 2'b00) ? v[0] : ((op == 2'b10) ? v[15] : 1'b0), v[15:1]};
            end
        end
        return {c, v};
    endfunction

    task automatic drive(input logic v0, input logic v1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [3:0] a0, input logic [3:0] a1,
                         input logic lr0, input logic lr1,
                         input logic [1:0] op0, input logic [1:0] op1);
        bus_if.req0_valid = v0;  bus_if.req1_valid = v1;
        bus_if.req0_data  = d0;  bus_if.req1_data  = d1;
        bus_if.req0_amt   = a0;  bus_if.req1_amt   = a1;
        bus_if.req0_lr    = lr0; bus_if.req1_lr    = lr1;
        bus_if.req0_op    = op0; bus_if.req1_op    = op1;
    endtask

    task automatic scramble(input logic allow_valid);
        drive(allow_valid & 1'($urandom), allow_valid & 1'($urandom),
              16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
    endtask

    // One full transaction: arbitration, accept, EXEC, RESP with stall cycles, then release.
    task automatic run_pair(input logic v0, input logic v1,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input logic [3:0] a0, input logic [3:0] a1,
                            input logic lr0, input logic lr1,
                            input logic [1:0] op0, input logic [1:0] op1,
                            input int stall);
        logic        g;
        logic [16:0] exp;
        if (v0 && v1) g = ~model_last;
        else          g = v1;
        exp = g ? ref_op(d1, a1, lr1, op1) : ref_op(d0, a0, lr0, op0);
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        drive(v0, v1, d0, d1, a0, a1, lr0, lr1, op0, op1);
        #1;
        chk("grant_ready0", 32'(bus_if.req0_ready), 32'(!g));
        chk("grant_ready1", 32'(bus_if.req1_ready), 32'(g));
        @(posedge clk);
        model_last = g;
        @(negedge clk);
        scramble(1'b1);
        #1;
        chk("exec_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("exec_no_ready", 32'(bus_if.req0_ready | bus_if.req1_ready), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        @(negedge clk);
        chk("resp_valid", 32'(bus_if.rsp_valid), 32'd1);
        chk("resp_data", 32'(bus_if.rsp_data), 32'(exp[15:0]));
        chk("resp_carry", 32'(bus_if.rsp_carry), 32'(exp[16]));
        chk("resp_zero", 32'(bus_if.rsp_zero), 32'(exp[15:0] == 16'h0000));
        chk("resp_id", 32'(bus_if.rsp_id), 32'(g));
        for (int k = 0; k < stall; k++) begin
            scramble(1'b1);
            @(negedge clk);
            chk("stall_valid", 32'(bus_if.rsp_valid), 32'd1);
            chk("stall_data", 32'(bus_if.rsp_data), 32'(exp[15:0]));
            chk("stall_carry", 32'(bus_if.rsp_carry), 32'(exp[16]));
            chk("stall_id", 32'(bus_if.rsp_id), 32'(g));
            chk("stall_no_ready", 32'(bus_if.req0_ready | bus_if.req1_ready), 32'd0);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        chk("release_idle", 32'(bus_if.rsp_valid), 32'd0);
    endtask

    logic grants[$];

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        bus_if.rsp_ready = 1'b0;
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 4'd3, 4'd3, 1'b1, 1'b1, 2'b00, 2'b00);

        // Reset state, with both requesters asserting valid.
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus_if.rsp_data), 32'd0);
        chk("rst_rsp_id", 32'(bus_if.rsp_id), 32'd0);
        chk("rst_rsp_carry", 32'(bus_if.rsp_carry), 32'd0);
        chk("rst_rsp_zero", 32'(bus_if.rsp_zero), 32'd0);
        chk("rst_ready", 32'(bus_if.req0_ready | bus_if.req1_ready), 32'd0);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        rst_n = 1'b1;
        model_last = 1'b1;

        // Both requesters held valid from reset: grants must go 0, 1, 0 and never be dual.
        bus_if.rsp_ready = 1'b1;
        @(negedge clk);
        drive(1'b1, 1'b1, 16'h00F0, 16'h0F00, 4'd4, 4'd4, 1'b1, 1'b0, 2'b01, 2'b01);
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("no_dual_ready", 32'(bus_if.req0_ready & bus_if.req1_ready), 32'd0);
            if (bus_if.req0_ready) grants.push_back(1'b0);
            if (bus_if.req1_ready) grants.push_back(1'b1);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        repeat (4) @(negedge clk);
        bus_if.rsp_ready = 1'b0;
        chk("rr_grant_count", 32'(grants.size() >= 3), 32'd1);
        if (grants.size() >= 3) begin
            chk("rr_grant_0", 32'(grants[0]), 32'd0);
            chk("rr_grant_1", 32'(grants[1]), 32'd1);
            chk("rr_grant_2", 32'(grants[2]), 32'd0);
            model_last = grants[grants.size() - 1];
        end

        // req0 rotate left by 1 of 0x8001, then req1 arithmetic/logical right cases.
        run_pair(1'b1, 1'b0, 16'h8001, 16'h0000, 4'd1, 4'd0, 1'b1, 1'b0, 2'b00, 2'b00, 0);
        chk("dir_rot_left", 32'(bus_if.rsp_data), 32'h0003);
        run_pair(1'b0, 1'b1, 16'h0000, 16'h8000, 4'd0, 4'd15, 1'b0, 1'b0, 2'b00, 2'b10, 0);
        chk("dir_asr15", 32'(bus_if.rsp_data), 32'hFFFF);
        run_pair(1'b0, 1'b1, 16'h0000, 16'h0001, 4'd0, 4'd1, 1'b0, 1'b0, 2'b00, 2'b01, 0);
        chk("dir_lsr1_zero", 32'(bus_if.rsp_zero), 32'd1);

        // A held response must stay stable for 5 cycles.
        run_pair(1'b1, 1'b0, 16'hA5C3, 16'h0000, 4'd5, 4'd0, 1'b0, 1'b0, 2'b10, 2'b00, 5);

        // amt=0 leaves data unchanged for every op. Pass ignores amt.
        run_pair(1'b1, 1'b0, 16'h1234, 16'h0000, 4'd0, 4'd0, 1'b1, 1'b0, 2'b00, 2'b00, 0);
        run_pair(1'b0, 1'b1, 16'h0000, 16'h1234, 4'd0, 4'd0, 1'b0, 1'b1, 2'b00, 2'b01, 0);
        run_pair(1'b1, 1'b0, 16'h1234, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10, 2'b00, 0);
        run_pair(1'b0, 1'b1, 16'h0000, 16'h1234, 4'd0, 4'd7, 1'b0, 1'b1, 2'b00, 2'b11, 0);

        // Reset pulse during EXEC drops the operation and restores the req0 tie priority.
        run_pair(1'b1, 1'b0, 16'h0001, 16'h0000, 4'd1, 4'd0, 1'b1, 1'b0, 2'b01, 2'b00, 0);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h4321, 16'h0000, 4'd2, 4'd0, 1'b1, 1'b0, 2'b00, 2'b00);
        #1;
        chk("pre_rst_ready0", 32'(bus_if.req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 4'd0, 4'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_exec_valid", 32'(bus_if.rsp_valid), 32'd0);
        #1;
        rst_n = 1'b1;
        model_last = 1'b1;
        @(negedge clk);
        chk("rst_exec_no_resp_a", 32'(bus_if.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_exec_no_resp_b", 32'(bus_if.rsp_valid), 32'd0);
        run_pair(1'b1, 1'b1, 16'h00FF, 16'hFF00, 4'd8, 4'd8, 1'b1, 1'b0, 2'b00, 2'b00, 0);

        // Randomized operations with random contention and random response stalls.
        for (int n = 0; n < 40; n++) begin
            logic v0, v1;
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            run_pair(v0, v1, 16'($urandom), 16'($urandom), 4'($urandom), 4'($urandom),
                     1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                     int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
